// File: rtl/wave_gen_pkg.sv
// Shared constants, types and helpers for the CORDIC quadrature tone generator.
// Angles are Q13 radians at the accumulator and Q15 radians inside the CORDIC.
package wave_gen_pkg;

  localparam int PHASE_W         = 16;
  localparam int DW              = 18;
  localparam int GUARD           = 2;
  localparam int OUT_W           = 16;
  localparam int N_STAGES        = 14;

  localparam int PI_Q13          = 25736;
  localparam int HALF_PI_Q13     = 12868;
  localparam int TWO_PI_Q13      = 51472;
  localparam int CORDIC_INV_GAIN = 9949;
  localparam int OUT_MAX         = 16384;

  // round(atan(2^-i) * 2^15)
  localparam logic signed [DW-1:0] ATAN_Q15 [N_STAGES] = '{
    18'sd25736, 18'sd15193, 18'sd8027, 18'sd4075, 18'sd2045, 18'sd1024, 18'sd512,
    18'sd256,   18'sd128,   18'sd64,   18'sd32,   18'sd16,   18'sd8,    18'sd4
  };

  typedef enum logic [1:0] {
    QuadNone = 2'd0,
    QuadPos  = 2'd1,
    QuadNeg  = 2'd2
  } quad_e;

  typedef struct packed {
    logic signed [DW-1:0] x;
    logic signed [DW-1:0] y;
    logic signed [DW-1:0] z;
    quad_e                quad;
  } cordic_t;

  localparam logic signed [DW-1:0]    RND_HALF   = 18'sd2;
  localparam logic signed [DW-1:0]    SAT_HI     = 18'sd16384;
  localparam logic signed [DW-1:0]    SAT_LO     = -18'sd16384;
  localparam logic signed [OUT_W-1:0] OUT_HI     = 16'sd16384;
  localparam logic signed [OUT_W-1:0] OUT_LO     = -16'sd16384;

  // Drop the fractional guard bits with round-half-up, then clamp to +/-1.0.
  function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [DW-1:0] v);
    logic signed [DW-1:0] r;
    r = (v + RND_HALF) >>> GUARD;
    if (r > SAT_HI) begin
      return OUT_HI;
    end else if (r < SAT_LO) begin
      return OUT_LO;
    end
    return r[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/cordic_stage.sv
// One registered rotation-mode CORDIC micro-rotation; Stage sets shift and atan constant.
module cordic_stage
  import wave_gen_pkg::*;
#(
  parameter int unsigned Stage = 0
) (
  input  logic    clk,
  input  logic    rst,
  input  cordic_t stage_i,
  output cordic_t stage_o
);

  localparam logic signed [DW-1:0] Atan = ATAN_Q15[Stage];

  cordic_t              stage_d, stage_q;
  logic signed [DW-1:0] x_in, y_in, z_in;
  logic signed [DW-1:0] x_sh, y_sh;

  always_comb begin
    x_in    = stage_i.x;
    y_in    = stage_i.y;
    z_in    = stage_i.z;
    x_sh    = x_in >>> Stage;
    y_sh    = y_in >>> Stage;
    stage_d = stage_i;
    if (z_in[DW-1]) begin
      stage_d.x = x_in + y_sh;
      stage_d.y = y_in - x_sh;
      stage_d.z = z_in + Atan;
    end else begin
      stage_d.x = x_in - y_sh;
      stage_d.y = y_in + x_sh;
      stage_d.z = z_in - Atan;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign stage_o = stage_q;

endmodule

// File: rtl/wave_gen_cordic.sv
// Free-running cos/sin tone source: Q13 phase accumulator, quadrant fold,
// 14-stage pipelined CORDIC and a saturating output register (17-clock latency).
module wave_gen_cordic
  import wave_gen_pkg::*;
#(
  parameter int PHASE_INC = 2145
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic signed [OUT_W-1:0] cos,
  output logic signed [OUT_W-1:0] sin
);

  localparam logic signed [PHASE_W:0]   PiExt  = 17'(PI_Q13);
  localparam logic signed [PHASE_W:0]   IncExt = 17'(PHASE_INC);
  localparam logic [PHASE_W-1:0]        TwoPi  = 16'(TWO_PI_Q13);
  localparam logic signed [PHASE_W-1:0] HalfPi = 16'(HALF_PI_Q13);
  // Start vector carries two fractional guard bits below the output LSB.
  localparam logic signed [DW-1:0]      X0     = 18'(CORDIC_INV_GAIN << GUARD);

  logic signed [PHASE_W-1:0] acc_d, acc_q;
  logic                      acc_vld_d, acc_vld_q;
  logic signed [PHASE_W:0]   acc_sum;

  // acc_vld_q holds the accumulator at 0 for the first edge out of reset, so that
  // phase 0 is the first sample to enter the fold stage.
  always_comb begin
    acc_sum   = {acc_q[PHASE_W-1], acc_q} + IncExt;
    acc_d     = acc_sum[PHASE_W-1:0];
    acc_vld_d = 1'b1;
    if (!acc_vld_q) begin
      acc_d = '0;
    end else if (acc_sum > PiExt) begin
      acc_d = acc_sum[PHASE_W-1:0] - TwoPi;
    end
  end

  cordic_t                   fold_d, fold_q;
  logic signed [PHASE_W-1:0] z_fold;

  always_comb begin
    fold_d = '0;
    z_fold = acc_q;
    if (acc_q > HalfPi) begin
      z_fold      = acc_q - HalfPi;
      fold_d.quad = QuadPos;
    end else if (acc_q < -HalfPi) begin
      z_fold      = acc_q + HalfPi;
      fold_d.quad = QuadNeg;
    end
    // Until the accumulator is live a zero vector is injected; it stays zero.
    if (acc_vld_q) begin
      fold_d.x = X0;
      fold_d.z = {z_fold, 2'b00};
    end else begin
      fold_d.quad = QuadNone;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      acc_vld_q <= 1'b0;
      fold_q    <= '0;
    end else begin
      acc_q     <= acc_d;
      acc_vld_q <= acc_vld_d;
      fold_q    <= fold_d;
    end
  end

  cordic_t pipe [N_STAGES+1];

  assign pipe[0] = fold_q;

  for (genvar i = 0; i < N_STAGES; i++) begin : g_stage
    cordic_stage #(
      .Stage(i)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .stage_i (pipe[i]),
      .stage_o (pipe[i+1])
    );
  end

  logic signed [DW-1:0]    x_end, y_end, x_rot, y_rot;
  logic signed [OUT_W-1:0] cos_d, cos_q, sin_d, sin_q;

  always_comb begin
    x_end = pipe[N_STAGES].x;
    y_end = pipe[N_STAGES].y;
    x_rot = x_end;
    y_rot = y_end;
    case (pipe[N_STAGES].quad)
      QuadPos: begin
        x_rot = -y_end;
        y_rot = x_end;
      end
      QuadNeg: begin
        x_rot = y_end;
        y_rot = -x_end;
      end
      default: ;
    endcase
    cos_d = sat_out(x_rot);
    sin_d = sat_out(y_rot);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cos_q <= '0;
      sin_q <= '0;
    end else begin
      cos_q <= cos_d;
      sin_q <= sin_d;
    end
  end

  assign cos = cos_q;
  assign sin = sin_q;

endmodule

// File: tb/tb_wave_gen_cordic.sv
// Bench: several generator instances share clock and reset; randomly timed reset
// pulses, every output compared with an ideal trig model of the phase sequence.
module tb_wave_gen_cordic;

  localparam int NI    = 5;
  localparam int INCS [NI] = '{0, 2145, 12868, 25735, 9001};
  localparam int LAT   = 17;
  localparam int NCYC  = 10000;
  localparam int TOL   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed [15:0] cos_w [NI];
  logic signed [15:0] sin_w [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    wave_gen_cordic #(
      .PHASE_INC(INCS[g])
    ) u_dut (
      .clk (clk),
      .rst (rst),
      .cos (cos_w[g]),
      .sin (sin_w[g])
    );
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input int got, input int exp, input int tol);
    n_vec++;
    if (got > exp + tol || got < exp - tol) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d) at %0t", tag, got, exp, tol, $time);
    end
  endtask

  function automatic int next_phase(input int p, input int inc);
    int n;
    n = p + inc;
    return (n > 25736) ? n - 51472 : n;
  endfunction

  function automatic int ideal(input int ph, input bit want_sin);
    real a, v;
    a = real'(ph) / 8192.0;
    v = 16384.0 * (want_sin ? $sin(a) : $cos(a));
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
  endfunction

  initial begin
    int since;
    int ph [NI];
    int gap;
    int pulse_left;
    int npulse;
    int c, s;
    since      = 0;
    pulse_left = 4;
    gap        = 300;
    npulse     = 0;
    for (int g = 0; g < NI; g++) ph[g] = 0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      if (rst) since = 0;
      else since++;
      @(negedge clk);

      for (int g = 0; g < NI; g++) begin
        c = cos_w[g];
        s = sin_w[g];
        if (since < LAT) begin
          check($sformatf("cos_zero[%0d] k=%0d", g, since), c, 0, 0);
          check($sformatf("sin_zero[%0d] k=%0d", g, since), s, 0, 0);
        end else begin
          ph[g] = (since == LAT) ? 0 : next_phase(ph[g], INCS[g]);
          check($sformatf("cos[%0d] ph=%0d", g, ph[g]), c, ideal(ph[g], 1'b0), TOL);
          check($sformatf("sin[%0d] ph=%0d", g, ph[g]), s, ideal(ph[g], 1'b1), TOL);
          check($sformatf("mag[%0d] ph=%0d", g, ph[g]), c * c + s * s, 1 << 28, 268435);
          check($sformatf("cos_rng[%0d]", g), c, 0, 16384);
          check($sformatf("sin_rng[%0d]", g), s, 0, 16384);
        end
      end

      // Reset schedule: 5-cycle pulses; the second lands while the pipeline fills.
      if (pulse_left > 0) begin
        rst = 1'b1;
        pulse_left--;
      end else if (gap == 0) begin
        rst        = 1'b1;
        pulse_left = 4;
        npulse++;
        gap = (npulse == 1) ? $urandom_range(3, 15) : $urandom_range(100, 1500);
      end else begin
        rst = 1'b0;
        gap--;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
